// File: rtl/hazard_scoreboard.sv
// Decode-to-issue hazard scoreboard: per-register write countdown, RAW/WAW stall, stall-cycle counter.
// Optional macro HAZARD_FWD_EN: readers may consume once the producer's countdown reaches ALU_LAT (forwarding).
module hazard_scoreboard #(
  parameter int REG_ADDR_W   = 4,
  parameter int NUM_REGS     = 16,
  parameter int LAT_W        = 3,
  parameter int ALU_LAT      = 3,
  parameter int MEM_LAT      = 4,
  parameter int IMPLICIT_REG = 14,
  parameter int STALL_CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   issue_valid,
  input  logic [REG_ADDR_W-1:0]  src1,
  input  logic                   src1_used,
  input  logic [REG_ADDR_W-1:0]  src2,
  input  logic                   src2_used,
  input  logic                   is_mem,
  input  logic [REG_ADDR_W-1:0]  dst,
  input  logic                   dst_used,
  input  logic                   lat_sel,
  input  logic                   flush,
  input  logic                   stall_clr,
  output logic                   stall,
  output logic                   issue_fire,
  output logic [NUM_REGS-1:0]    busy_mask,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam logic [LAT_W-1:0]       ALU_L  = LAT_W'(ALU_LAT);
  localparam logic [LAT_W-1:0]       MEM_L  = LAT_W'(MEM_LAT);
  localparam logic [LAT_W-1:0]       ONE_L  = LAT_W'(1);
  localparam logic [LAT_W-1:0]       ZERO_L = {LAT_W{1'b0}};
  localparam logic [REG_ADDR_W-1:0]  IMP_R  = REG_ADDR_W'(IMPLICIT_REG);
  localparam logic [REG_ADDR_W-1:0]  ZERO_R = {REG_ADDR_W{1'b0}};
  localparam logic [STALL_CNT_W-1:0] CNT_MAX = {STALL_CNT_W{1'b1}};
  localparam logic [STALL_CNT_W-1:0] CNT_ONE = STALL_CNT_W'(1);
`ifdef HAZARD_FWD_EN
  localparam logic [LAT_W-1:0]       TH = ALU_L;
`else
  localparam logic [LAT_W-1:0]       TH = ZERO_L;
`endif

  logic [LAT_W-1:0]       pend_r [NUM_REGS];
  logic [STALL_CNT_W-1:0] cnt_r;
  logic [LAT_W-1:0]       lat_s;
  logic                   raw_s;
  logic                   waw_s;
  logic                   stall_s;
  logic                   fire_s;

  // r0 reads never hazard because r0 is never written
  function automatic logic read_hazard(input logic used, input logic [REG_ADDR_W-1:0] r,
                                       input logic [LAT_W-1:0] p);
    return used && (r != ZERO_R) && (p > TH);
  endfunction

  // Hazard detection and issue decision
  always_comb begin
    lat_s   = lat_sel ? MEM_L : ALU_L;
    raw_s   = read_hazard(src1_used, src1, pend_r[src1]) |
              read_hazard(src2_used, src2, pend_r[src2]) |
              read_hazard(is_mem, IMP_R, pend_r[IMP_R]);
    waw_s   = dst_used && (dst != ZERO_R) && (pend_r[dst] > lat_s);
    stall_s = issue_valid & (raw_s | waw_s);
    fire_s  = issue_valid & ~stall_s & ~flush;
  end

  // Busy view of the countdown array
  always_comb begin
    busy_mask = {NUM_REGS{1'b0}};
    for (int r = 0; r < NUM_REGS; r++) begin
      busy_mask[r] = (pend_r[r] != ZERO_L);
    end
  end

  // Countdown per register; a newly issued write reloads its entry instead of decrementing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) pend_r[r] <= ZERO_L;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (r == 0) begin
          pend_r[r] <= ZERO_L;
        end else if (fire_s && dst_used && (dst == REG_ADDR_W'(r))) begin
          pend_r[r] <= lat_s;
        end else if (pend_r[r] != ZERO_L) begin
          pend_r[r] <= pend_r[r] - ONE_L;
        end else begin
          pend_r[r] <= pend_r[r];
        end
      end
    end
  end

  // Saturating stall-cycle counter; clear wins over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {STALL_CNT_W{1'b0}};
    end else if (stall_clr) begin
      cnt_r <= {STALL_CNT_W{1'b0}};
    end else if (stall_s && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign stall       = stall_s;
  assign issue_fire  = fire_s;
  assign stall_count = cnt_r;

endmodule
